fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised successor of the CPU front end. It merges the instruction store, program download,
//  byte-order fix-up and fetch sequencing into one block with explicit run control.
//  It supplies Decode with an instruction stream and takes the branch delta and flush from Execute.
//  A run/halt FSM replaces clock gating for download, so the core clock never stops.
// PARAMETERS
//  ADDR_W      8        index width; store depth = 2**ADDR_W words
//  INSTR_W     16       instruction width; must be a multiple of 8
//  SWAP_BYTES  1        1: byte-reverse each word on write (little-endian image); 0: store as-is
//  START_INDEX 0        fetch index loaded on entry to RUN
//  HALT_WORD   16'hDEFE instruction (after swap) that stops fetch
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  load_valid   in   1        download word offered
//  load_ready   out  1        block accepts download words (IDLE only)
//  load_index   in   ADDR_W   store address for load_data
//  load_data    in   INSTR_W  raw program word
//  run          in   1        level: 1 = execute, 0 = return to IDLE
//  stall        in   1        hold fetch: index and instruction output frozen
//  delta_valid  in   1        Execute requests a branch this cycle
//  delta_i      in   32       signed branch delta, relative to current index
//  flush        in   1        squash the instruction presented next cycle (global_disable)
//  instruction  out  INSTR_W  instruction to Decode
//  instr_valid  out  1        instruction is on the correct path and must be decoded
//  index        out  ADDR_W   index of the word being fetched this cycle
//  halted       out  1        FSM in HALT
//  issued       out  32       count of cycles with instr_valid=1 since last RUN entry
// BEHAVIOUR
//  Reset: state IDLE; index=START_INDEX; instruction=0; instr_valid=0; halted=0; issued=0; load_ready=1 the next cycle.
//   Store contents are not cleared.
//  States and transitions:
//   IDLE: load_ready=1. A write occurs when load_valid and load_ready are both 1; the word is swapped if SWAP_BYTES.
//     run=1 -> RUN; index<=START_INDEX; issued<=0. A write in the same cycle still completes.
//   RUN: load_ready=0. Read is synchronous, 1-cycle latency: instruction(t+1)=mem[index(t)].
//     instr_valid(t+1)=1 unless flush(t)=1 or stall(t)=1.
//     Next index: stall -> hold. delta_valid -> index+delta_i[ADDR_W-1:0]. Otherwise index+1.
//     stall has priority over delta_valid; delta_valid during stall is ignored.
//     Index arithmetic wraps modulo 2**ADDR_W in both directions.
//     A presented instruction equal to HALT_WORD with instr_valid=1 -> HALT next cycle.
//       That HALT_WORD is itself counted in issued.
//     run=0 -> IDLE next cycle; instr_valid<=0.
//   HALT: instr_valid=0; index frozen; halted=1; issued frozen.
//     run=0 -> IDLE. run=1 holds HALT; re-entry to RUN requires passing through IDLE.
//  Output rules:
//   While stalled, instruction is held at its last value and instr_valid=0.
//   issued increments by 1 per cycle with instr_valid=1 and saturates at 32'hFFFFFFFF.
//   flush and delta_valid together: the redirect is taken and the next instruction is squashed.
//   reset mid-download or mid-RUN aborts immediately to the reset state; partial writes already done stay in the store.
// TESTING
//  1. Load 0x3412 at 0, 0x7856 at 1 (SWAP_BYTES=1), then run=1.
//     -> instruction 16'h1234, then 16'h5678, on consecutive cycles with instr_valid=1 and index 1, 2.
//  2. RUN at index 5, delta_valid=1, delta_i=-3, flush=1.
//     -> next index 2; one cycle instr_valid=0; then mem[2] is valid.
//  3. ADDR_W=4, index 15, no branch -> index wraps to 0. Delta +20 from index 3 -> index 7.
//  4. HALT_WORD stored at 3; run from 0.
//     -> three valid instructions, then HALT_WORD valid, then halted=1 and issued=4.
//     run=0 -> IDLE with load_ready=1.
//  5. stall held 3 cycles during RUN -> index and instruction frozen, instr_valid=0; sequence resumes unchanged.
//  6. reset asserted mid-RUN -> next cycle state IDLE, index=0, instr_valid=0, issued=0.
//     load_valid during RUN -> no write (load_ready=0).

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction front end combining the instruction store, program
// download, byte-order fix-up and fetch sequencing under a run/halt FSM.
//
// Ports:
//   clk, reset     single rising-edge clock, synchronous active-high reset
//   load_valid     download word offered
//   load_ready     download words accepted (IDLE only)
//   load_index     store address for load_data
//   load_data      raw program word (byte-reversed on write when SWAP_BYTES)
//   run            level: 1 = execute, 0 = return to IDLE
//   stall          freeze fetch index and presented instruction
//   delta_valid    branch request from Execute
//   delta_i        signed branch delta relative to the current index
//   flush          squash the instruction presented next cycle
//   instruction    instruction to Decode
//   instr_valid    presented instruction must be decoded
//   index          index of the word being fetched this cycle
//   halted         FSM in HALT
//   issued         saturating count of valid cycles since last RUN entry
module fetch_unit #(
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          INSTR_W     = 16,
  parameter bit                   SWAP_BYTES  = 1'b1,
  parameter logic [ADDR_W-1:0]    START_INDEX = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD   = 'hDEFE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [ADDR_W-1:0]  load_index,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               run,
  input  logic               stall,
  input  logic               delta_valid,
  input  logic [31:0]        delta_i,
  input  logic               flush,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  index,
  output logic               halted,
  output logic [31:0]        issued
);

  localparam int unsigned NBYTES = INSTR_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    index_q, index_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [31:0]          issued_q, issued_d;
  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [INSTR_W-1:0]   wr_data;

  function automatic logic [INSTR_W-1:0] byte_swap(input logic [INSTR_W-1:0] w);
    logic [INSTR_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      r[8*b +: 8] = w[INSTR_W-8-8*b +: 8];
    end
    return r;
  endfunction

  assign wr_data = SWAP_BYTES ? byte_swap(load_data) : load_data;

  // Store is never cleared by reset; writes only happen while IDLE.
  always_ff @(posedge clk) begin
    if (load_valid && load_ready) begin
      mem[load_index] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    issued_d = issued_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_RUN;
          index_d  = START_INDEX;
          issued_d = '0;
        end
      end
      ST_RUN: begin
        if (valid_q && (issued_q != '1)) begin
          issued_d = issued_q + 32'd1;
        end
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          if (!stall) begin
            instr_d = mem[index_q];
            valid_d = !flush;
            index_d = delta_valid ? index_q + delta_i[ADDR_W-1:0]
                                  : index_q + 1'b1;
          end
          // The halt word is judged on the presented instruction, so the
          // fetch already in flight this cycle is discarded.
          if (valid_q && (instr_q == HALT_WORD)) begin
            state_d = ST_HALT;
            valid_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        if (!run) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      index_q  <= START_INDEX;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
    end
  end

  assign load_ready  = (state_q == ST_IDLE);
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign index       = index_q;
  assign halted      = (state_q == ST_HALT);
  assign issued      = issued_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (ADDR_W=4 to exercise wrap).
module tb_fetch_unit;

  localparam int unsigned AW = 4;
  localparam int unsigned IW = 16;

  logic          clk;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_index;
  logic [IW-1:0] load_data;
  logic          run;
  logic          stall;
  logic          delta_valid;
  logic [31:0]   delta_i;
  logic          flush;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [AW-1:0] index;
  logic          halted;
  logic [31:0]   issued;

  int unsigned tests;
  int unsigned fails;

  fetch_unit #(
    .ADDR_W      (AW),
    .INSTR_W     (IW),
    .SWAP_BYTES  (1'b1),
    .START_INDEX (4'd0),
    .HALT_WORD   (16'hDEFE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_index  (load_index),
    .load_data   (load_data),
    .run         (run),
    .stall       (stall),
    .delta_valid (delta_valid),
    .delta_i     (delta_i),
    .flush       (flush),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .index       (index),
    .halted      (halted),
    .issued      (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] raw);
    load_valid = 1'b1;
    load_index = a;
    load_data  = raw;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] lo;
    tests = 0;
    fails = 0;
    reset = 1'b1; load_valid = 1'b0; load_index = '0; load_data = '0;
    run = 1'b0; stall = 1'b0; delta_valid = 1'b0; delta_i = '0; flush = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_instr",  32'(instruction), 32'h0);
    chk("rst_valid",  32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted),      32'h0);
    chk("rst_issued", issued,           32'h0);
    chk("rst_index",  32'(index),       32'h0);
    chk("rst_ready",  32'(load_ready),  32'h1);

    // Image is little-endian: raw 0x3412 lands as 0x1234.
    load(4'd0, 16'h3412);
    load(4'd1, 16'h7856);
    // Words 2..15 stored as 0xA0nn, i.e. raw bytes {nn, A0}.
    for (int unsigned i = 2; i < 16; i++) begin
      lo = 8'(i);
      load(4'(i), {lo, 8'hA0});
    end

    // Test 1: first two instructions after RUN entry.
    run = 1'b1;
    step();                                   // E1
    chk("t1_idx0",   32'(index),      32'h0);
    chk("t1_ready0", 32'(load_ready), 32'h0);
    chk("t1_val0",   32'(instr_valid), 32'h0);
    step();                                   // E2
    chk("t1_instA",  32'(instruction), 32'h1234);
    chk("t1_valA",   32'(instr_valid), 32'h1);
    chk("t1_idxA",   32'(index),       32'h1);
    step();                                   // E3
    chk("t1_instB",  32'(instruction), 32'h5678);
    chk("t1_valB",   32'(instr_valid), 32'h1);
    chk("t1_idxB",   32'(index),       32'h2);
    chk("t1_issued", issued,           32'd1);
    step(); step(); step();                   // E6: index 5
    chk("t2_pre_idx", 32'(index),       32'h5);
    chk("t2_pre_ins", 32'(instruction), 32'hA004);

    // Test 2: branch -3 with flush from index 5.
    delta_valid = 1'b1; delta_i = -32'sd3; flush = 1'b1;
    step();                                   // E7
    delta_valid = 1'b0; delta_i = '0; flush = 1'b0;
    chk("t2_idx",    32'(index),       32'h2);
    chk("t2_squash", 32'(instr_valid), 32'h0);
    step();                                   // E8
    chk("t2_ins",    32'(instruction), 32'hA002);
    chk("t2_val",    32'(instr_valid), 32'h1);
    chk("t2_idx2",   32'(index),       32'h3);

    // Test 3: +20 from index 3 wraps to 7, then sequential wrap 15 -> 0.
    delta_valid = 1'b1; delta_i = 32'd20;
    step();                                   // E9
    delta_valid = 1'b0; delta_i = '0;
    chk("t3_fwd_idx", 32'(index),       32'h7);
    chk("t3_fwd_ins", 32'(instruction), 32'hA003);
    for (int k = 0; k < 8; k++) step();       // E17
    chk("t3_idx15",  32'(index),       32'hF);
    step();                                   // E18
    chk("t3_wrap",   32'(index),       32'h0);
    chk("t3_wins",   32'(instruction), 32'hA00F);
    chk("t3_issued", issued,           32'd15);
    delta_valid = 1'b1; delta_i = -32'sd3;
    step();                                   // E19
    delta_valid = 1'b0; delta_i = '0;
    chk("t3_back_idx", 32'(index),       32'hD);
    chk("t3_back_ins", 32'(instruction), 32'h1234);

    // Test 5: 3-cycle stall; a branch request during stall is ignored.
    stall = 1'b1; delta_valid = 1'b1; delta_i = 32'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_idx", 32'(index),       32'hD);
      chk("t5_ins", 32'(instruction), 32'h1234);
      chk("t5_val", 32'(instr_valid), 32'h0);
    end
    stall = 1'b0; delta_valid = 1'b0; delta_i = '0;
    step();                                   // E23
    chk("t5_res_ins", 32'(instruction), 32'hA00D);
    chk("t5_res_val", 32'(instr_valid), 32'h1);
    chk("t5_res_idx", 32'(index),       32'hE);

    // Test 6: download attempt during RUN must not write (checked in test 4).
    load_valid = 1'b1; load_index = 4'd2; load_data = 16'hFFFF;
    chk("t6_ready_run", 32'(load_ready), 32'h0);
    step();
    load_valid = 1'b0;

    // Test 6: reset mid-RUN.
    reset = 1'b1;
    step();
    reset = 1'b0;
    run = 1'b0;
    chk("t6_idx",    32'(index),       32'h0);
    chk("t6_val",    32'(instr_valid), 32'h0);
    chk("t6_issued", issued,           32'h0);
    chk("t6_halted", 32'(halted),      32'h0);
    chk("t6_ready",  32'(load_ready),  32'h1);

    // Test 4: HALT_WORD at index 3 (raw bytes reversed).
    load(4'd3, 16'hFEDE);
    run = 1'b1;
    step();                                   // R1
    step();                                   // R2
    chk("t4_i0", 32'(instruction), 32'h1234);
    step();                                   // R3
    chk("t4_i1", 32'(instruction), 32'h5678);
    step();                                   // R4
    chk("t4_i2_nowrite", 32'(instruction), 32'hA002);
    step();                                   // R5
    chk("t4_halt_ins", 32'(instruction), 32'hDEFE);
    chk("t4_halt_val", 32'(instr_valid), 32'h1);
    chk("t4_iss3",     issued,           32'd3);
    chk("t4_not_yet",  32'(halted),      32'h0);
    step();                                   // R6
    chk("t4_halted", 32'(halted),      32'h1);
    chk("t4_val0",   32'(instr_valid), 32'h0);
    chk("t4_issued", issued,           32'd4);
    chk("t4_idx",    32'(index),       32'h5);
    step();                                   // R7: run still high holds HALT
    chk("t4_hold_h",   32'(halted), 32'h1);
    chk("t4_hold_idx", 32'(index),  32'h5);
    chk("t4_hold_iss", issued,      32'd4);
    run = 1'b0;
    step();                                   // R8
    chk("t4_idle_h",     32'(halted),      32'h0);
    chk("t4_idle_ready", 32'(load_ready),  32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
